// File: rtl/logic64_seq_pkg.sv
// Shared definitions for the sequential 64-bit logic unit.
// Holds op encodings, FSM state encoding and width constants.
package logic64_seq_pkg;

  localparam int LS_XLEN  = 64;
  localparam int LS_SLICE = 32;

  typedef enum logic [1:0] {
    OP_AND = 2'b00,
    OP_OR  = 2'b01,
    OP_XOR = 2'b10,
    OP_RSV = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    LOW  = 2'b01,
    HIGH = 2'b10,
    DONE = 2'b11
  } state_e;

endpackage

// File: rtl/logic64_seq_logic32_slice.sv
// Combinational 32-bit AND/OR/XOR selector; the reserved op yields zero.
module logic32_slice
  import logic64_seq_pkg::*;
(
  input  logic [1:0]          op,
  input  logic [LS_SLICE-1:0] a,
  input  logic [LS_SLICE-1:0] b,
  output logic [LS_SLICE-1:0] y
);

  logic [LS_SLICE-1:0] xor_y;

  xor32b u_xor (
    .a (a),
    .b (b),
    .y (xor_y)
  );

  always_comb begin
    y = '0;
    case (op)
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_XOR:  y = xor_y;
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/xor32b.sv
// Existing verified 32-bit XOR slice used on the XOR path of logic32_slice.
module xor32b (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] y
);

  assign y = a ^ b;

endmodule

// File: rtl/logic64_seq.sv
// 64-bit bitwise logic unit processing one 32-bit slice per cycle (LOW then HIGH).
// Optional zero-result flag port enabled by defining LOGIC64_SEQ_ZERO_FLAG_EN.
module logic64_seq
  import logic64_seq_pkg::*;
#(
  parameter int XLEN  = LS_XLEN,
  parameter int SLICE = LS_SLICE
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            err,
  output logic            busy
`ifdef LOGIC64_SEQ_ZERO_FLAG_EN
  ,
  output logic            zero
`endif
);

  state_e            state_q, state_d;
  logic [XLEN-1:0]   a_q, b_q, result_q;
  logic [1:0]        op_q;
  logic              err_q;
  logic [SLICE-1:0]  slice_a, slice_b, slice_y;

  // One shared slice: the low half is fed in LOW, the high half in HIGH.
  assign slice_a = (state_q == HIGH) ? a_q[XLEN-1:SLICE] : a_q[SLICE-1:0];
  assign slice_b = (state_q == HIGH) ? b_q[XLEN-1:SLICE] : b_q[SLICE-1:0];

  logic32_slice u_slice (
    .op (op_q),
    .a  (slice_a),
    .b  (slice_b),
    .y  (slice_y)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid) state_d = LOW;
      LOW:     state_d = HIGH;
      HIGH:    state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      result_q <= '0;
      err_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (in_valid) begin
          a_q   <= a;
          b_q   <= b;
          op_q  <= op;
          err_q <= 1'b0;
        end
        LOW:  result_q[SLICE-1:0] <= slice_y;
        HIGH: begin
          result_q[XLEN-1:SLICE] <= slice_y;
          err_q                  <= (op_q == OP_RSV);
        end
        default: ;
      endcase
    end
  end

`ifdef LOGIC64_SEQ_ZERO_FLAG_EN
  logic zero_q;

  // Evaluated in HIGH: the low half is already registered, the high half is in flight.
  always_ff @(posedge clk) begin
    if (reset)                zero_q <= 1'b0;
    else if (state_q == HIGH) zero_q <= (result_q[SLICE-1:0] == '0) && (slice_y == '0);
  end

  assign zero = zero_q;
`endif

  assign in_ready  = (state_q == IDLE) && !reset;
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign result    = result_q;
  assign err       = err_q;

endmodule

// File: tb/tb_logic64_seq.sv
// Scoreboard bench for logic64_seq: driver pushes expected results, negedge monitor pops on handshake.
module tb_logic64_seq;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [1:0]  op = 2'b00;
  logic [63:0] a = '0;
  logic [63:0] b = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [63:0] result;
  logic        err;
  logic        busy;
`ifdef LOGIC64_SEQ_ZERO_FLAG_EN
  logic        zero;
`endif

  logic64_seq dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .err       (err),
    .busy      (busy)
`ifdef LOGIC64_SEQ_ZERO_FLAG_EN
    ,
    .zero      (zero)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] res;
    logic        err;
    logic        zero;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  bit   rand_bp = 1'b0;
  logic or_cmd = 1'b1;

  function automatic logic [63:0] model(input logic [1:0] o, input logic [63:0] x, input logic [63:0] y);
    case (o)
      2'b00:   return x & y;
      2'b01:   return x | y;
      2'b10:   return x ^ y;
      default: return 64'h0;
    endcase
  endfunction

  task automatic chk64(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%b required=%b", name, act, exp);
    end
  endtask

  // out_ready changes just after the rising edge, so it is stable at the negedge sample.
  always @(posedge clk) begin
    #1;
    out_ready = rand_bp ? 1'($urandom_range(0, 1)) : or_cmd;
  end

  logic        prev_hold = 1'b0;
  logic [63:0] prev_res = '0;
  logic        prev_err = 1'b0;

  always @(negedge clk) begin
    exp_t e;
    if (!reset && out_valid) begin
      if (prev_hold) begin
        chk64("hold_result", result, prev_res);
        chk1("hold_err", err, prev_err);
      end
      if (out_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output actual=%h required=no_output", result);
        end else begin
          e = sb.pop_front();
          chk64("result", result, e.res);
          chk1("err", err, e.err);
`ifdef LOGIC64_SEQ_ZERO_FLAG_EN
          chk1("zero", zero, e.zero);
`endif
        end
        prev_hold = 1'b0;
      end else begin
        prev_hold = 1'b1;
        prev_res  = result;
        prev_err  = err;
      end
    end else begin
      prev_hold = 1'b0;
    end
  end

  task automatic issue(input logic [1:0] o, input logic [63:0] x, input logic [63:0] y, input bit push);
    exp_t e;
    int   n;
    @(posedge clk);
    #2;
    in_valid = 1'b1;
    op = o;
    a  = x;
    b  = y;
    n  = 0;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      n++;
      if (n > 60) begin
        checks++;
        errors++;
        $display("FAIL accept_timeout actual=in_ready_low required=in_ready_high");
        in_valid = 1'b0;
        return;
      end
    end
    @(posedge clk);
    #2;
    in_valid = 1'b0;
    op = 2'($urandom);
    a  = {$urandom, $urandom};
    b  = {$urandom, $urandom};
    if (push) begin
      e.res  = model(o, x, y);
      e.err  = (o == 2'b11);
      e.zero = (e.res == 64'h0);
      sb.push_back(e);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 || busy) begin
      @(negedge clk);
      n++;
      if (n > 400) begin
        checks++;
        errors++;
        $display("FAIL drain_timeout actual=%0d required=0", sb.size());
        return;
      end
    end
  endtask

  initial begin
    int   n;
    bit   seen;
    logic [63:0] x, y;

    // Reset with a request pending: it must be ignored.
    in_valid = 1'b1;
    a = 64'h1234;
    b = 64'h5678;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk1("reset_in_ready", in_ready, 1'b0);
    chk1("reset_out_valid", out_valid, 1'b0);
    chk1("reset_busy", busy, 1'b0);
    chk1("reset_err", err, 1'b0);
    chk64("reset_result", result, 64'h0);
    in_valid = 1'b0;
    @(posedge clk);
    #2;
    reset = 1'b0;
    @(negedge clk);
    chk1("idle_in_ready", in_ready, 1'b1);
    chk1("idle_busy", busy, 1'b0);

    // 1: XOR, latency and in_ready low while busy
    issue(2'b10, 64'hFFFF0000_12345678, 64'h0F0F0F0F_FFFFFFFF, 1'b1);
    seen = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk1("busy_in_ready", in_ready, 1'b0);
      if (out_valid) seen = 1'b1;
    end
    chk1("latency_out_valid", seen, 1'b1);
    drain();

    // 2: AND then OR on the same operands
    issue(2'b00, 64'hAAAAAAAA_AAAAAAAA, 64'h5555FFFF_0000FFFF, 1'b1);
    issue(2'b01, 64'hAAAAAAAA_AAAAAAAA, 64'h5555FFFF_0000FFFF, 1'b1);
    drain();

    // 3: backpressure in DONE with a competing request
    or_cmd = 1'b0;
    @(posedge clk);
    issue(2'b10, 64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 1'b1);
    n = 0;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk1("bp_out_valid", out_valid, 1'b1);
    @(posedge clk);
    #2;
    in_valid = 1'b1;
    op = 2'b00;
    a  = 64'hFFFF_FFFF_0000_FFFF;
    b  = 64'h0F0F_0F0F_0F0F_0F0F;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk1("bp_in_ready", in_ready, 1'b0);
      chk1("bp_out_valid_held", out_valid, 1'b1);
    end
    or_cmd = 1'b1;
    issue(2'b00, 64'hFFFF_FFFF_0000_FFFF, 64'h0F0F_0F0F_0F0F_0F0F, 1'b1);
    drain();

    // 4: reserved op flags err, next op clears it
    issue(2'b11, 64'h1, 64'h1, 1'b1);
    drain();
    issue(2'b10, 64'h1, 64'h1, 1'b1);
    drain();

    // 5: reset while in HIGH discards the operation
    issue(2'b10, 64'hDEAD_0000_0000_BEEF, 64'h0000_1111_2222_0000, 1'b0);
    @(posedge clk);
    #2;
    reset = 1'b1;
    @(posedge clk);
    #2;
    reset = 1'b0;
    @(negedge clk);
    chk1("midreset_busy", busy, 1'b0);
    chk1("midreset_out_valid", out_valid, 1'b0);
    chk64("midreset_result", result, 64'h0);
    chk1("midreset_in_ready", in_ready, 1'b1);
    repeat (4) begin
      @(negedge clk);
      chk1("midreset_no_pulse", out_valid, 1'b0);
    end
    issue(2'b10, 64'hDEADBEEF_CAFEF00D, 64'h1, 1'b1);
    drain();

    // 6: zero-result cases (zero flag checked when the feature is built in)
    issue(2'b10, 64'hDEADBEEF_CAFEF00D, 64'hDEADBEEF_CAFEF00D, 1'b1);
    issue(2'b10, 64'h1, 64'h0, 1'b1);
    issue(2'b00, 64'hFFFF_FFFF_0000_0000, 64'h0000_0000_FFFF_FFFF, 1'b1);
    drain();

    // Randomized ops with random backpressure
    rand_bp = 1'b1;
    for (int i = 0; i < 40; i++) begin
      x = {$urandom, $urandom};
      y = {$urandom, $urandom};
      if ($urandom_range(0, 7) == 0) y = x;
      issue(2'($urandom_range(0, 3)), x, y, 1'b1);
    end
    drain();
    rand_bp = 1'b0;
    repeat (3) @(posedge clk);

    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_empty actual=%0d required=0", sb.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
